ps2_scancode_rx: RTL and testbench
==================================

// Module: ps2_scancode_rx
// PURPOSE
//  Fully synchronous PS/2 device-to-host receiver with a scan-code prefix decoder.
//  - kclk/kdata are sampled in the system clock domain only; no logic is clocked by kclk.
//  - Checks start, odd parity and stop bits, and times out stalled frames.
//  - Folds E0 (extended) and F0 (break) prefixes into one key event per key.
//  - Sits between the PS/2 pins and the keyboard command/game-control logic.
// PARAMETERS
//  CLK_HZ        100_000_000  system clock frequency, Hz
//  FILTER_LEN    20           consecutive equal samples needed to accept a new kclk/kdata level (>=2)
//  TIMEOUT_US    2000         max gap between filtered kclk falling edges inside a frame, us
//  PARITY_CHECK  1            1: bad parity -> parity_err and byte dropped; 0: parity bit ignored
//  localparam TIMEOUT_CYC = CLK_HZ/1_000_000*TIMEOUT_US
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous reset, active high
//  kclk        in   1  PS/2 clock pin, asynchronous
//  kdata       in   1  PS/2 data pin, asynchronous
//  rx_byte     out  8  last good raw byte
//  rx_valid    out  1  1-cycle strobe: rx_byte updated
//  key_code    out  8  decoded key code (prefixes removed)
//  key_ext     out  1  key_code had an E0 prefix
//  key_brk     out  1  key_code had an F0 prefix (release)
//  key_valid   out  1  1-cycle strobe: key_code/key_ext/key_brk updated
//  parity_err  out  1  1-cycle strobe: parity mismatch
//  frame_err   out  1  1-cycle strobe: stop bit 0 or timeout
//  busy        out  1  high while FSM is not IDLE
// BEHAVIOUR
//  - Reset:
//    - All outputs 0; FSM in IDLE; ext/brk prefix flags 0.
//    - Filtered kclk/kdata levels and sync flops are set to 1 (idle bus).
//  - Input conditioning:
//    - Each pin passes through a 2-FF synchroniser, then a counter filter.
//    - The filtered level changes only after FILTER_LEN consecutive samples at the new value.
//    - fall = filtered kclk 1->0 in this cycle; at most one fall per cycle.
//  - FSM, acting only on cycles with fall unless noted:
//    - IDLE: if kdata_f==0 (start bit) -> DATA, bit index 0; if kdata_f==1 -> stay in IDLE.
//    - DATA: shift kdata_f in LSB first; after the 8th bit -> PARITY.
//    - PARITY: capture the parity bit -> STOP.
//    - STOP: if kdata_f==1 and parity is odd over 9 bits (or PARITY_CHECK=0):
//      rx_byte <= data, rx_valid pulses on the next cycle.
//    - STOP, stop bit 0: frame_err pulses.
//    - STOP, stop bit 1 but parity bad: parity_err pulses.
//    - STOP, all cases: -> IDLE.
//    - Stop 0 and bad parity together: frame_err only.
//  - Timeout:
//    - The gap counter clears on every fall and on entry to IDLE.
//    - Outside IDLE, when the count reaches TIMEOUT_CYC: frame_err pulses, FSM -> IDLE,
//      partial byte discarded.
//    - Fall and terminal count in the same cycle: the fall wins and no timeout occurs.
//  - Latency: rx_valid, parity_err and frame_err are registered, 1 clk after the stop-bit fall.
//  - Prefix decoder (driven only by the rx_valid byte):
//    - 8'hE0 sets ext; 8'hF0 sets brk; neither byte raises key_valid.
//    - Any other byte, including E1: key_code <= byte, key_ext <= ext, key_brk <= brk,
//      key_valid pulses 1 clk after rx_valid, then ext and brk clear.
//    - parity_err or frame_err clears ext and brk.
//    - key_* outputs hold their values between strobes.
//  - rst mid-frame: the frame is abandoned and no strobes are issued.
//    The next start bit after reset is decoded normally.
// STRUCTURE
//  - ps2_pkg holds:
//    - state enum {IDLE, DATA, PARITY, STOP};
//    - PS2_PFX_EXT = 8'hE0 and PS2_PFX_BRK = 8'hF0.
//  - Sub-module ps2_sync_filter (2-FF sync + FILTER_LEN counter filter, reset level 1),
//    instantiated once for kclk and once for kdata.
//  - Top level holds the FSM, gap timer and prefix decoder.
// TESTING  (bench: CLK_HZ=1_000_000, FILTER_LEN=4, TIMEOUT_US=200, PS/2 bit period 60 clk)
//  1. Frame 0x1C with parity 0 -> one rx_valid with rx_byte=1C; one key_valid with key_code=1C, ext=0, brk=0.
//  2. Bytes F0,1C then E0,F0,75 -> key_valid twice only: (1C, ext=0, brk=1), then (75, ext=1, brk=1).
//  3. F0, then 0x1C sent with parity 1, then good 1C -> parity_err pulse with no rx_valid;
//     final key_valid has key_code=1C, brk=0.
//  4. 0x1C with stop bit 0 -> frame_err pulse, no rx_valid, busy low 1 clk later.
//  5. 4 data bits, then kclk held high 300 clk -> frame_err at gap 200;
//     a following good 0x29 gives key_code=29.
//  6. 2-clk kclk low glitch in IDLE, then rst asserted mid-frame -> no strobes;
//     a following good 0x5A gives key_code=5A.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 scan-code receiver.
//   - ps2_state_t : receive FSM states
//   - PS2_PFX_EXT : extended-key prefix byte (E0)
//   - PS2_PFX_BRK : break (key release) prefix byte (F0)
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // Odd parity over data plus parity bit: true when the 9-bit word has an odd count of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{par, data};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter
//   Brings one asynchronous PS/2 pin into the clk domain and debounces it.
//   A 2-FF synchroniser feeds a counter filter: the output level only changes
//   after FILTER_LEN consecutive synchronised samples at the new value.
//   Ports:
//     clk   in  system clock
//     rst   in  synchronous reset, active high (all flops reset to 1 = idle bus)
//     pin   in  raw asynchronous pin
//     level out filtered, synchronised level
module ps2_sync_filter #(
    parameter int FILTER_LEN = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level
);

    localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 != level) begin
                // cnt counts earlier differing samples; this one makes FILTER_LEN.
                if (cnt == CW'(FILTER_LEN - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                // Any sample back at the current level restarts the run.
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   Fully synchronous PS/2 device-to-host receiver with a scan-code prefix decoder.
//   kclk/kdata are only sampled by clk; a filtered kclk falling edge advances the FSM.
//   Ports:
//     clk, rst          system clock, synchronous active-high reset
//     kclk, kdata       raw PS/2 pins (asynchronous)
//     rx_byte/rx_valid  last good raw byte, 1-cycle strobe when updated
//     key_code/key_ext/key_brk/key_valid
//                       decoded key event (E0/F0 prefixes folded in), 1-cycle strobe
//     parity_err        1-cycle strobe: parity mismatch, byte dropped
//     frame_err         1-cycle strobe: stop bit 0 or inter-edge timeout
//     busy              high while the receive FSM is not IDLE
//   Strobe semantics: every *_valid / *_err output is high for exactly one clk and its
//   companion data outputs are stable in that cycle and hold until the next strobe;
//   there is no back-pressure, the consumer must take the data in the strobe cycle.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int FILTER_LEN   = 20,
    parameter int TIMEOUT_US   = 2000,
    parameter int PARITY_CHECK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       key_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int GAP_W       = $clog2(TIMEOUT_CYC + 1);

    // ---------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------
    logic kclk_f;
    logic kdata_f;
    logic kclk_f_d;
    logic fall;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk_filt (
        .clk   (clk),
        .rst   (rst),
        .pin   (kclk),
        .level (kclk_f)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata_filt (
        .clk   (clk),
        .rst   (rst),
        .pin   (kdata),
        .level (kdata_f)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            kclk_f_d <= 1'b1;
        end else begin
            kclk_f_d <= kclk_f;
        end
    end

    assign fall = kclk_f_d & ~kclk_f;

    // ---------------------------------------------------------------
    // Receive FSM and gap timer
    // ---------------------------------------------------------------
    ps2_state_t       state;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par_bit;
    logic [GAP_W-1:0] gap_cnt;
    logic             par_ok;
    logic             timeout;

    assign par_ok  = (PARITY_CHECK == 0) || ps2_parity_ok(shreg, par_bit);
    // A fall in the terminal-count cycle keeps the frame alive.
    assign timeout = (state != IDLE) && !fall && (gap_cnt == GAP_W'(TIMEOUT_CYC));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            gap_cnt    <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            // Gap timer: idles at zero, restarts on every fall inside a frame.
            if (state == IDLE || fall) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_W'(TIMEOUT_CYC)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            if (timeout) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                gap_cnt   <= '0;
            end else if (fall) begin
                unique case (state)
                    IDLE: begin
                        if (!kdata_f) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {kdata_f, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= kdata_f;
                        state   <= STOP;
                    end
                    STOP: begin
                        // A bad stop bit dominates a parity error.
                        if (!kdata_f) begin
                            frame_err <= 1'b1;
                        end else if (!par_ok) begin
                            parity_err <= 1'b1;
                        end else begin
                            rx_byte  <= shreg;
                            rx_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Prefix decoder: folds E0/F0 into the following key byte
    // ---------------------------------------------------------------
    logic ext_flag;
    logic brk_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_brk   <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (parity_err || frame_err) begin
                // A lost byte may have been the key the prefixes belonged to.
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == PS2_PFX_EXT) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == PS2_PFX_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    key_code  <= rx_byte;
                    key_ext   <= ext_flag;
                    key_brk   <= brk_flag;
                    key_valid <= 1'b1;
                    ext_flag  <= 1'b0;
                    brk_flag  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx
//   Directed bench for ps2_scancode_rx. Driver tasks emit PS/2 frames (60 clk bit
//   period); expected raw bytes, key events and error strobes are queued by the
//   stimulus and popped by a monitor whenever the DUT strobes.
module tb_ps2_scancode_rx;

    logic       clk;
    logic       rst;
    logic       kclk;
    logic       kdata;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_brk;
    logic       key_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Expected queues: raw bytes, key events {ext,brk,code}, errors {frame,parity}.
    logic [7:0]  exp_rx_q[$];
    logic [9:0]  exp_key_q[$];
    logic [1:0]  exp_err_q[$];

    ps2_scancode_rx #(
        .CLK_HZ       (1_000_000),
        .FILTER_LEN   (4),
        .TIMEOUT_US   (200),
        .PARITY_CHECK (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .kclk       (kclk),
        .kdata      (kdata),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_brk    (key_brk),
        .key_valid  (key_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run did not finish within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drives bits[0..n-1] LSB first; data changes mid-high, kclk low for 30 clk.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            kdata = bits[i];
            repeat (15) @(posedge clk);
            kclk = 1'b0;
            repeat (30) @(posedge clk);
            kclk = 1'b1;
            repeat (15) @(posedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par, input logic stop);
        send_bits({stop, par, b, 1'b0}, 11);
        kdata = 1'b1;
        repeat (60) @(posedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (exp_rx_q.size() == 0) begin
                    check("unexpected_rx_valid", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_rx_q.pop_front()});
                end
            end
            if (key_valid) begin
                if (exp_key_q.size() == 0) begin
                    check("unexpected_key_valid", {22'd0, key_ext, key_brk, key_code}, 32'hFFFF_FFFF);
                end else begin
                    check("key_event", {22'd0, key_ext, key_brk, key_code}, {22'd0, exp_key_q.pop_front()});
                end
            end
            if (parity_err || frame_err) begin
                if (exp_err_q.size() == 0) begin
                    check("unexpected_err", {30'd0, frame_err, parity_err}, 32'hFFFF_FFFF);
                end else begin
                    check("err_kind", {30'd0, frame_err, parity_err}, {30'd0, exp_err_q.pop_front()});
                end
                check("busy_after_err", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic check_drained(input string tag);
        check({tag, "_rx_q_left"},  exp_rx_q.size(),  0);
        check({tag, "_key_q_left"}, exp_key_q.size(), 0);
        check({tag, "_err_q_left"}, exp_err_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        kclk  = 1'b1;
        kdata = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rx_byte",  {24'd0, rx_byte}, 32'd0);
        check("reset_key_code", {24'd0, key_code}, 32'd0);
        check("reset_strobes",  {27'd0, rx_valid, key_valid, parity_err, frame_err, busy}, 32'd0);
        check("reset_key_flags", {30'd0, key_ext, key_brk}, 32'd0);
        repeat (20) @(posedge clk);

        // 1: 0x1C, three ones -> parity bit 0.
        exp_rx_q.push_back(8'h1C);
        exp_key_q.push_back({1'b0, 1'b0, 8'h1C});
        send_byte(8'h1C, 1'b0, 1'b1);
        check_drained("t1");

        // 2: F0 1C -> release 1C; E0 F0 75 -> extended release 75.
        // Parities: F0 (4 ones) -> 1, E0 (3 ones) -> 0, 75 (5 ones) -> 0.
        exp_rx_q.push_back(8'hF0);
        exp_rx_q.push_back(8'h1C);
        exp_key_q.push_back({1'b0, 1'b1, 8'h1C});
        send_byte(8'hF0, 1'b1, 1'b1);
        send_byte(8'h1C, 1'b0, 1'b1);
        exp_rx_q.push_back(8'hE0);
        exp_rx_q.push_back(8'hF0);
        exp_rx_q.push_back(8'h75);
        exp_key_q.push_back({1'b1, 1'b1, 8'h75});
        send_byte(8'hE0, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b1, 1'b1);
        send_byte(8'h75, 1'b0, 1'b1);
        check("t2_key_hold", {22'd0, key_ext, key_brk, key_code}, {22'd0, 2'b11, 8'h75});
        check_drained("t2");

        // 3: F0, then 1C with wrong parity (1), then good 1C -> brk cleared by the error.
        exp_rx_q.push_back(8'hF0);
        send_byte(8'hF0, 1'b1, 1'b1);
        exp_err_q.push_back(2'b01);
        send_byte(8'h1C, 1'b1, 1'b1);
        exp_rx_q.push_back(8'h1C);
        exp_key_q.push_back({1'b0, 1'b0, 8'h1C});
        send_byte(8'h1C, 1'b0, 1'b1);
        check_drained("t3");

        // 4: 0x1C with stop bit 0 -> frame_err only.
        exp_err_q.push_back(2'b10);
        send_byte(8'h1C, 1'b0, 1'b0);
        check_drained("t4");

        // 5: start + 4 data bits, then kclk idle high 300 clk -> timeout frame_err.
        exp_err_q.push_back(2'b10);
        send_bits({6'b0, 4'b1100, 1'b0}, 5);
        kdata = 1'b1;
        repeat (300) @(posedge clk);
        check("t5_busy_after_timeout", {31'd0, busy}, 32'd0);
        exp_rx_q.push_back(8'h29);
        exp_key_q.push_back({1'b0, 1'b0, 8'h29});
        send_byte(8'h29, 1'b0, 1'b1);   // 0x29 has 3 ones
        check_drained("t5");

        // 6: 2-clk kclk glitch in IDLE must be filtered out.
        kclk = 1'b0;
        repeat (2) @(posedge clk);
        kclk = 1'b1;
        repeat (20) @(posedge clk);
        check("t6_busy_after_glitch", {31'd0, busy}, 32'd0);
        // Start a frame, then reset mid-frame: no strobes expected.
        send_bits({7'b0, 3'b101, 1'b0}, 4);
        check("t6_busy_mid_frame", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy_after_rst", {31'd0, busy}, 32'd0);
        repeat (60) @(posedge clk);
        exp_rx_q.push_back(8'h5A);
        exp_key_q.push_back({1'b0, 1'b0, 8'h5A});
        send_byte(8'h5A, 1'b1, 1'b1);   // 0x5A has 4 ones
        check("t6_key_code", {24'd0, key_code}, 32'h5A);
        check_drained("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
